// File: rtl/stunir_call_arbiter.sv
// Round-robin arbiter/sequencer sharing one start/done function unit among NUM_REQ requesters.
// Optional WAIT timeout with RECOVER state: define STUNIR_CALL_ARB_TIMEOUT_EN.
module stunir_call_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
    parameter int TIMEOUT = 1024,
`endif
    localparam int IDW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [DATA_W-1:0]  resp_data,
    output logic               resp_err,
    output logic [IDW-1:0]     owner,
    output logic               busy,
    output logic               fu_start,
    input  logic               fu_done,
    input  logic [DATA_W-1:0]  fu_result
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
        RESP    = 3'd3,
        RECOVER = 3'd4
`else
        RESP    = 3'd3
`endif
    } state_t;

    state_t               state_r, state_s;
    logic [IDW-1:0]       ptr_r, ptr_s, owner_r, owner_s;
    logic [NUM_REQ-1:0]   ack_r, ack_s;
    logic [DATA_W-1:0]    resp_data_r, resp_data_s;
    logic                 busy_r, busy_s, fu_start_r, fu_start_s;
    logic                 first_wait_r, first_wait_s;
    logic [2*NUM_REQ-1:0] req2_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic                 found_s;
    logic [IDW:0]         sum_s;
    logic [IDW-1:0]       grant_s, ptr_next_s;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
    logic [15:0]          cnt_r, cnt_s;
    logic                 resp_err_r, resp_err_s;
    logic                 timeout_s;
`endif

    // Rotate requests so the pointer sits at bit 0; lowest set bit of the rotation wins.
    always_comb begin
        req2_s  = {req, req};
        rot_s   = req2_s[ptr_r +: NUM_REQ];
        found_s = 1'b0;
        sum_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum_s   = rot_s[i] ? ({1'b0, ptr_r} + (IDW+1)'(i)) : sum_s;
            found_s = found_s | rot_s[i];
        end
        grant_s    = (sum_s >= (IDW+1)'(NUM_REQ)) ? IDW'(sum_s - (IDW+1)'(NUM_REQ)) : IDW'(sum_s);
        ptr_next_s = (grant_s == IDW'(NUM_REQ - 1)) ? IDW'(0) : grant_s + IDW'(1);
    end

    // Next-state and next-output logic; every output is loaded into a register.
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        owner_s      = owner_r;
        ack_s        = '0;
        resp_data_s  = resp_data_r;
        fu_start_s   = 1'b0;
        first_wait_s = first_wait_r;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
        cnt_s        = cnt_r;
        resp_err_s   = resp_err_r;
        timeout_s    = ((cnt_r + 16'd1) == 16'(TIMEOUT));
`endif
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s    = ISSUE;
                    owner_s    = grant_s;
                    ptr_s      = ptr_next_s;
                    fu_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s      = WAIT;
                first_wait_s = 1'b1;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
                cnt_s        = 16'd0;
`endif
            end
            WAIT: begin
                first_wait_s = 1'b0;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
                cnt_s        = cnt_r + 16'd1;
`endif
                // A done level left over from the previous call is ignored in the first WAIT cycle.
                if (fu_done && !first_wait_r) begin
                    state_s     = RESP;
                    ack_s       = NUM_REQ'(1) << owner_r;
                    resp_data_s = fu_result;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
                    resp_err_s  = 1'b0;
                end else if (timeout_s) begin
                    state_s     = RESP;
                    ack_s       = NUM_REQ'(1) << owner_r;
                    resp_data_s = '0;
                    resp_err_s  = 1'b1;
`endif
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
                state_s = resp_err_r ? RECOVER : IDLE;
            end
            RECOVER: begin
                if (fu_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = RECOVER;
                end
`else
                state_s = IDLE;
`endif
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            owner_r      <= '0;
            ack_r        <= '0;
            resp_data_r  <= '0;
            busy_r       <= 1'b0;
            fu_start_r   <= 1'b0;
            first_wait_r <= 1'b0;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
            cnt_r        <= 16'd0;
            resp_err_r   <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            owner_r      <= owner_s;
            ack_r        <= ack_s;
            resp_data_r  <= resp_data_s;
            busy_r       <= busy_s;
            fu_start_r   <= fu_start_s;
            first_wait_r <= first_wait_s;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
            cnt_r        <= cnt_s;
            resp_err_r   <= resp_err_s;
`endif
        end
    end

    assign ack       = ack_r;
    assign resp_data = resp_data_r;
    assign owner     = owner_r;
    assign busy      = busy_r;
    assign fu_start  = fu_start_r;
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
    assign resp_err  = resp_err_r;
`else
    assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_stunir_call_arbiter.sv
// Scoreboard bench for stunir_call_arbiter with a start/done function-unit model.
module tb_stunir_call_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [1:0]  owner;
    logic        busy;
    logic        fu_start;
    logic        fu_done;
    logic [31:0] fu_result;

    stunir_call_arbiter #(
`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
        .TIMEOUT (8),
`endif
        .NUM_REQ (4),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .owner     (owner),
        .busy      (busy),
        .fu_start  (fu_start),
        .fu_done   (fu_done),
        .fu_result (fu_result)
    );

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] data;
        logic        err;
        logic [1:0]  own;
        int          cyc;
    } exp_t;

    exp_t        resp_q[$];
    int          start_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // function-unit model controls
    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    logic        m_drop     = 1'b0;
    int          m_cnt      = 0;
    int          m_lat      = 2;
    bit          stale_mode = 1'b0;
    logic [31:0] m_res      = 32'h0;
    logic [31:0] next_result = 32'h0;

    assign fu_done   = model_done | force_done;
    assign fu_result = m_res;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Unit: done rises on the m_lat-th edge after the start edge and stays high until the next start.
    always @(posedge clk) begin
        if (rst) begin
            model_done <= 1'b0;
            m_cnt      <= 0;
            m_drop     <= 1'b0;
        end else if (fu_start) begin
            m_cnt <= m_lat;
            if (stale_mode) m_drop <= 1'b1;
            else            model_done <= 1'b0;
        end else begin
            if (m_drop) begin
                model_done <= 1'b0;
                m_drop     <= 1'b0;
            end
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    model_done <= 1'b1;
                    m_res      <= next_result;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: compare every start pulse and every ack against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (fu_start) begin
                if (start_q.size() == 0) check_eq("spurious_start", 32'(fu_start), 32'd0);
                else                     check_eq("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
            end
            if (ack != 4'b0000) begin
                if (resp_q.size() == 0) begin
                    check_eq("spurious_ack", 32'(ack), 32'd0);
                end else begin
                    exp_t e;
                    e = resp_q.pop_front();
                    check_eq("ack_vec",   32'(ack),      32'(e.ack));
                    check_eq("ack_cycle", 32'(cyc),      32'(e.cyc));
                    check_eq("resp_data", resp_data,     e.data);
                    check_eq("resp_err",  32'(resp_err), 32'(e.err));
                    check_eq("owner",     32'(owner),    32'(e.own));
                    check_eq("busy_ack",  32'(busy),     32'd1);
                end
            end
        end
    end

    // Issue one call from an IDLE-cycle negedge; returns at the negedge of the next IDLE cycle.
    task automatic do_call(input logic [3:0] r, input logic [31:0] res, input int lat,
                           input bit stale, input logic [1:0] own, input int dly, input bit err);
        exp_t e;
        int   n;
        req         = r;
        next_result = res;
        m_lat       = lat;
        stale_mode  = stale;
        e.ack  = 4'b0001 << own;
        e.data = err ? 32'h0 : res;
        e.err  = err;
        e.own  = own;
        e.cyc  = cyc + dly;
        start_q.push_back(cyc + 1);
        resp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0000 && n < 100);
        if (ack == 4'b0000) begin
            check_eq("ack_wait", 32'd0, 32'd1);
            resp_q.delete();
            start_q.delete();
        end
        req = 4'b0000;
        @(negedge clk);
        stale_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ack",      32'(ack),      32'd0);
        check_eq("rst_data",     resp_data,     32'd0);
        check_eq("rst_err",      32'(resp_err), 32'd0);
        check_eq("rst_owner",    32'(owner),    32'd0);
        check_eq("rst_busy",     32'(busy),     32'd0);
        check_eq("rst_fu_start", 32'(fu_start), 32'd0);

        // single call, then wrap from pointer 3 with 1001
        do_call(4'b0100, 32'hDEADBEEF, 2, 1'b0, 2'd2, 5, 1'b0);
        do_call(4'b1001, 32'h11110003, 2, 1'b0, 2'd3, 5, 1'b0);
        do_call(4'b1001, 32'h22220000, 2, 1'b0, 2'd0, 5, 1'b0);
        // stale done held through ISSUE and first WAIT cycle
        do_call(4'b0010, 32'h5A5A0001, 2, 1'b1, 2'd1, 5, 1'b0);

        // reset in the first WAIT cycle
        req         = 4'b0100;
        next_result = 32'hBAD0BAD0;
        m_lat       = 2;
        start_q.push_back(cyc + 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ack",      32'(ack),      32'd0);
        check_eq("mid_rst_data",     resp_data,     32'd0);
        check_eq("mid_rst_owner",    32'(owner),    32'd0);
        check_eq("mid_rst_busy",     32'(busy),     32'd0);
        check_eq("mid_rst_fu_start", 32'(fu_start), 32'd0);
        rst = 1'b0;
        req = 4'b0000;
        repeat (8) @(negedge clk);

        // fairness from pointer 0 with all requesters active
        do_call(4'b1111, 32'hA0000000, 2, 1'b0, 2'd0, 5, 1'b0);
        do_call(4'b1111, 32'hA0000001, 2, 1'b0, 2'd1, 5, 1'b0);
        do_call(4'b1111, 32'hA0000002, 2, 1'b0, 2'd2, 5, 1'b0);
        do_call(4'b1111, 32'hA0000003, 2, 1'b0, 2'd3, 5, 1'b0);
        do_call(4'b1111, 32'hA0000004, 2, 1'b0, 2'd0, 5, 1'b0);

`ifdef STUNIR_CALL_ARB_TIMEOUT_EN
        // unit never completes: error ack after 8 WAIT cycles, then RECOVER until done
        do_call(4'b0010, 32'hCAFEF00D, 0, 1'b0, 2'd1, 10, 1'b1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            check_eq("recover_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        req        = 4'b0000;
        force_done = 1'b1;
        @(negedge clk);
        check_eq("recover_exit_busy", 32'(busy), 32'd0);
        force_done = 1'b0;
        repeat (2) @(negedge clk);
`endif

        check_eq("start_q_left", 32'(start_q.size()), 32'd0);
        check_eq("resp_q_left",  32'(resp_q.size()),  32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
